// File: rtl/rv64_pkg.sv
// Shared RV64I decode definitions.
// Holds the major opcode values, the funct3/funct7 constants used by the
// legality checks, the immediate-format selector and a helper that applies
// the funct7/funct3 pairing rules shared by OP and OP-32.
package rv64_pkg;

  // Major opcodes (instr[6:0]); all legal ones end in 2'b11
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // funct3 values that the legality rules care about
  localparam logic [2:0] F3_ADD_SUB  = 3'b000;
  localparam logic [2:0] F3_SLL      = 3'b001;
  localparam logic [2:0] F3_SR       = 3'b101;
  localparam logic [2:0] F3_JALR     = 3'b000;
  localparam logic [2:0] F3_FENCE    = 3'b000;
  localparam logic [2:0] F3_BR_RSV0  = 3'b010;
  localparam logic [2:0] F3_BR_RSV1  = 3'b011;
  localparam logic [2:0] F3_LD_RSV   = 3'b111;

  // funct7 values for register-register ops
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // instr[31:26] patterns for 64-bit immediate shifts (shamt is 6 bits)
  localparam logic [5:0] SHIFT_HI_BASE = 6'b000000;
  localparam logic [5:0] SHIFT_HI_SRA  = 6'b010000;

  // The only two SYSTEM encodings accepted
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // funct7 must be base or alternate; the alternate form exists only for
  // SUB and SRA.
  function automatic logic op_funct_illegal(input logic [6:0] funct7,
                                            input logic [2:0] funct3);
    logic bad;
    bad = 1'b1;
    if (funct7 == F7_BASE) begin
      bad = 1'b0;
    end else if (funct7 == F7_ALT) begin
      bad = !((funct3 == F3_ADD_SUB) || (funct3 == F3_SR));
    end else begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator (module imm_gen).
// Purely combinational: reassembles and sign-extends the immediate of the
// selected instruction format to 64 bits.
// Ports:
//   instr    in  32  raw instruction word
//   imm_type in  3   immediate format selector
//   imm      out 64  sign-extended immediate (0 for IMM_NONE)
module imm_gen
  import rv64_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_type_e   imm_type,
  output logic [63:0] imm
);

  // Format-dependent bit gather with sign extension from instr[31]
  always_comb begin
    imm = 64'd0;
    case (imm_type)
      IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      // U-type upper 32 bits are the sign of the 32-bit result
      IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'd0};
      IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      IMM_NONE: imm = 64'd0;
      default: imm = 64'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage.
// Accepts {pc, instr} from fetch over valid/ready, decodes register indices,
// immediate, write-enable, word-op and illegal flags, and holds the result in
// a one-entry pipeline register for execute. Supports back-pressure and flush.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        fetch handshake
//   in_pc[63:0], in_instr    incoming pc and raw instruction
//   flush                    drops held entry and any same-cycle input
//   out_valid/out_ready      execute handshake
//   out_pc .. out_illegal    registered decoded fields
module decode_stage
  import rv64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [63:0] out_imm,
  output logic        out_reg_we,
  output logic        out_is_word,
  output logic        out_illegal
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [4:0]  rd_s;
  logic [63:0] imm_s;
  logic        reg_we_s;
  logic        is_word_s;
  logic        illegal_s;
  imm_type_e   imm_type_s;
  logic        load_s;

  logic        valid_r;
  logic [63:0] pc_r;
  logic [6:0]  opcode_r;
  logic [2:0]  funct3_r;
  logic [6:0]  funct7_r;
  logic [4:0]  rs1_r;
  logic [4:0]  rs2_r;
  logic [4:0]  rd_r;
  logic [63:0] imm_r;
  logic        reg_we_r;
  logic        is_word_r;
  logic        illegal_r;

  assign opcode_s = in_instr[6:0];
  assign funct3_s = in_instr[14:12];
  assign funct7_s = in_instr[31:25];

  // Ready is not gated by flush: a flushed input is simply not loaded
  assign in_ready = !valid_r || out_ready;
  assign load_s   = in_valid && in_ready && !flush;

  imm_gen u_imm_gen (
    .instr    (in_instr),
    .imm_type (imm_type_s),
    .imm      (imm_s)
  );

  // Per-opcode field selection and legality; unlisted opcodes (including
  // any with instr[1:0] != 2'b11) fall to the default and are illegal.
  always_comb begin
    imm_type_s = IMM_NONE;
    rs1_s      = in_instr[19:15];
    rs2_s      = 5'd0;
    rd_s       = in_instr[11:7];
    is_word_s  = 1'b0;
    illegal_s  = 1'b0;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC: begin
        imm_type_s = IMM_U;
        rs1_s      = 5'd0;
      end
      OPC_JAL: begin
        imm_type_s = IMM_J;
        rs1_s      = 5'd0;
      end
      OPC_JALR: begin
        imm_type_s = IMM_I;
        illegal_s  = (funct3_s != F3_JALR);
      end
      OPC_BRANCH: begin
        imm_type_s = IMM_B;
        rs2_s      = in_instr[24:20];
        rd_s       = 5'd0;
        illegal_s  = (funct3_s == F3_BR_RSV0) || (funct3_s == F3_BR_RSV1);
      end
      OPC_LOAD: begin
        imm_type_s = IMM_I;
        illegal_s  = (funct3_s == F3_LD_RSV);
      end
      OPC_STORE: begin
        imm_type_s = IMM_S;
        rs2_s      = in_instr[24:20];
        rd_s       = 5'd0;
        // only SB/SH/SW/SD (funct3 0..3)
        illegal_s  = funct3_s[2];
      end
      OPC_OP_IMM: begin
        imm_type_s = IMM_I;
        case (funct3_s)
          F3_SLL:  illegal_s = (in_instr[31:26] != SHIFT_HI_BASE);
          F3_SR:   illegal_s = (in_instr[31:26] != SHIFT_HI_BASE) &&
                               (in_instr[31:26] != SHIFT_HI_SRA);
          default: illegal_s = 1'b0;
        endcase
      end
      OPC_OP_IMM_32: begin
        imm_type_s = IMM_I;
        is_word_s  = 1'b1;
        case (funct3_s)
          F3_ADD_SUB:   illegal_s = 1'b0;
          // word shifts have a 5-bit shamt, so instr[25] must be clear
          F3_SLL, F3_SR: illegal_s = in_instr[25];
          default:      illegal_s = 1'b1;
        endcase
      end
      OPC_OP: begin
        rs2_s     = in_instr[24:20];
        illegal_s = op_funct_illegal(funct7_s, funct3_s);
      end
      OPC_OP_32: begin
        rs2_s     = in_instr[24:20];
        is_word_s = 1'b1;
        case (funct3_s)
          F3_ADD_SUB, F3_SLL, F3_SR: illegal_s = op_funct_illegal(funct7_s, funct3_s);
          default:                   illegal_s = 1'b1;
        endcase
      end
      OPC_MISC_MEM: begin
        rd_s      = 5'd0;
        illegal_s = (funct3_s != F3_FENCE);
      end
      OPC_SYSTEM: begin
        rd_s      = 5'd0;
        illegal_s = (in_instr != INSTR_ECALL) && (in_instr != INSTR_EBREAK);
      end
      default: begin
        rs2_s     = in_instr[24:20];
        illegal_s = 1'b1;
      end
    endcase
  end

  // rd is already zeroed for S/B types, so only rd!=0 and legality remain
  assign reg_we_s = (rd_s != 5'd0) && !illegal_s;

  // Pipeline register: reset > flush > load > pop; otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r   <= 1'b0;
      pc_r      <= 64'd0;
      opcode_r  <= 7'd0;
      funct3_r  <= 3'd0;
      funct7_r  <= 7'd0;
      rs1_r     <= 5'd0;
      rs2_r     <= 5'd0;
      rd_r      <= 5'd0;
      imm_r     <= 64'd0;
      reg_we_r  <= 1'b0;
      is_word_r <= 1'b0;
      illegal_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load_s) begin
      valid_r   <= 1'b1;
      pc_r      <= in_pc;
      opcode_r  <= opcode_s;
      funct3_r  <= funct3_s;
      funct7_r  <= funct7_s;
      rs1_r     <= rs1_s;
      rs2_r     <= rs2_s;
      rd_r      <= rd_s;
      imm_r     <= imm_s;
      reg_we_r  <= reg_we_s;
      is_word_r <= is_word_s;
      illegal_r <= illegal_s;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid   = valid_r;
  assign out_pc      = pc_r;
  assign out_opcode  = opcode_r;
  assign out_funct3  = funct3_r;
  assign out_funct7  = funct7_r;
  assign out_rs1     = rs1_r;
  assign out_rs2     = rs2_r;
  assign out_rd      = rd_r;
  assign out_imm     = imm_r;
  assign out_reg_we  = reg_we_r;
  assign out_is_word = is_word_r;
  assign out_illegal = illegal_r;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [63:0] out_imm;
  logic        out_reg_we;
  logic        out_is_word;
  logic        out_illegal;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        we;
    logic        word;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_reg_we(out_reg_we), .out_is_word(out_is_word), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Expected entry built from hand-decoded values
  function automatic exp_t mk(input logic [31:0] instr, input logic [63:0] pc,
                              input logic [6:0] opc, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [63:0] imm, input logic we,
                              input logic word, input logic ill);
    exp_t e;
    e.instr = instr; e.pc = pc; e.opcode = opc; e.funct3 = f3; e.funct7 = f7;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
    e.we = we; e.word = word; e.ill = ill;
    return e;
  endfunction

  // Drive one transaction; push expectation when the handshake will fire
  task automatic send(input exp_t e, input bit push);
    bit accepted;
    accepted = 1'b0;
    in_pc    = e.pc;
    in_instr = e.instr;
    in_valid = 1'b1;
    for (int c = 0; c < 20 && !accepted; c++) begin
      #1;
      if (in_ready) begin
        if (push) sb.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: pc 0x%0h not accepted within 20 cycles", e.pc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_pc"}, out_pc, 64'd0);
    check({tag, "_fields"}, {25'd0, out_opcode, out_funct3, out_funct7,
                             out_rs1, out_rs2, out_rd, out_reg_we, out_is_word,
                             out_illegal}, 64'd0);
    check({tag, "_imm"}, out_imm, 64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  // Monitor: every consumed entry must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: pc 0x%0h with empty scoreboard", out_pc);
        end else begin
          e = sb.pop_front();
          check("pc", out_pc, e.pc);
          check("opcode", {57'd0, out_opcode}, {57'd0, e.opcode});
          check("funct3", {61'd0, out_funct3}, {61'd0, e.funct3});
          check("funct7", {57'd0, out_funct7}, {57'd0, e.funct7});
          check("rs1", {59'd0, out_rs1}, {59'd0, e.rs1});
          check("rs2", {59'd0, out_rs2}, {59'd0, e.rs2});
          check("rd", {59'd0, out_rd}, {59'd0, e.rd});
          check("imm", out_imm, e.imm);
          check("reg_we", {63'd0, out_reg_we}, {63'd0, e.we});
          check("is_word", {63'd0, out_is_word}, {63'd0, e.word});
          check("illegal", {63'd0, out_illegal}, {63'd0, e.ill});
        end
      end
    end
  end

  initial begin
    exp_t va, vb, vd, ve, vf;
    rst = 1'b1; in_valid = 1'b0; in_pc = 64'd0; in_instr = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    #1;
    check_zero_state("reset");

    // addi x1,x0,-1
    send(mk(32'hFFF00093, 64'h1000, 7'h13, 3'd0, 7'h7F, 5'd0, 5'd0, 5'd1,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0), 1'b1);
    // sd x2,8(x3)
    send(mk(32'h0021B423, 64'h1004, 7'h23, 3'd3, 7'h00, 5'd3, 5'd2, 5'd0,
            64'd8, 1'b0, 1'b0, 1'b0), 1'b1);
    // beq x1,x2,-4
    send(mk(32'hFE208EE3, 64'h1008, 7'h63, 3'd0, 7'h7F, 5'd1, 5'd2, 5'd0,
            64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0), 1'b1);
    // lui x5,0x80000
    send(mk(32'h800002B7, 64'h100C, 7'h37, 3'd0, 7'h40, 5'd0, 5'd0, 5'd5,
            64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, 1'b0), 1'b1);
    // jal x1,8
    send(mk(32'h008000EF, 64'h1010, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1,
            64'd8, 1'b1, 1'b0, 1'b0), 1'b1);
    // addiw x1,x1,1
    send(mk(32'h0010809B, 64'h1014, 7'h1B, 3'd0, 7'h00, 5'd1, 5'd0, 5'd1,
            64'd1, 1'b1, 1'b1, 1'b0), 1'b1);
    // all-zero word: illegal
    send(mk(32'h00000000, 64'h1018, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,
            64'd0, 1'b0, 1'b0, 1'b1), 1'b1);
    // OP funct7=0100000 with funct3=111: illegal
    send(mk(32'h4000F033, 64'h101C, 7'h33, 3'd7, 7'h20, 5'd1, 5'd0, 5'd0,
            64'd0, 1'b0, 1'b0, 1'b1), 1'b1);
    // ebreak: legal
    send(mk(32'h00100073, 64'h1020, 7'h73, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,
            64'd0, 1'b0, 1'b0, 1'b0), 1'b1);
    // slliw with instr[25]=1: illegal, rd kept but no write
    send(mk(32'h0200909B, 64'h1024, 7'h1B, 3'd1, 7'h01, 5'd1, 5'd0, 5'd1,
            64'd32, 1'b0, 1'b1, 1'b1), 1'b1);

    // Back-pressure: hold A for 3 cycles while B waits, then pop+load together
    idle(1);
    va = mk(32'h00A10113, 64'h2000, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd2,
            64'd10, 1'b1, 1'b0, 1'b0);
    vb = mk(32'h008000EF, 64'h2004, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1,
            64'd8, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(va, 1'b1);
    in_pc = vb.pc; in_instr = vb.instr; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_pc", out_pc, va.pc);
      check("stall_imm", out_imm, va.imm);
      check("stall_rd", {59'd0, out_rd}, {59'd0, va.rd});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    sb.push_back(vb);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("same_cycle_load_valid", {63'd0, out_valid}, 64'd1);
    check("same_cycle_load_pc", out_pc, vb.pc);

    // Flush a held entry together with a same-cycle input
    idle(1);
    vd = mk(32'h00A10113, 64'h3000, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd2,
            64'd10, 1'b1, 1'b0, 1'b0);
    ve = mk(32'hFFF00093, 64'h3004, 7'h13, 3'd0, 7'h7F, 5'd0, 5'd0, 5'd1,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(vd, 1'b0);
    check("pre_flush_valid", {63'd0, out_valid}, 64'd1);
    in_pc = ve.pc; in_instr = ve.instr; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    idle(1);
    check("flush_not_loaded", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;

    // Reset while stalled clears everything
    vf = mk(32'h0021B423, 64'h4000, 7'h23, 3'd3, 7'h00, 5'd3, 5'd2, 5'd0,
            64'd8, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(vf, 1'b0);
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero_state("stall_rst");
    out_ready = 1'b1;

    // Drain: every expected entry must have been consumed
    for (int c = 0; c < 50 && sb.size() != 0; c++) idle(1);
    idle(2);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
